// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: I2C slave that turns bus traffic into single-Clk memory strobes
// (address lookup, byte write, byte read) with open-drain SDA drive.
module i2c_slave_controller #(
  parameter int ADDRESSLENGTH = 8
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     Scl,
  input  logic                     SdaIn,
  output logic                     SdaPullLow,
  output logic                     MemEnable,
  output logic                     MemMode,
  output logic                     MemRorW,
  output logic [ADDRESSLENGTH-1:0] MemAddress,
  output logic [7:0]               MemWrData,
  input  logic [7:0]               MemRdData,
  input  logic                     AddressFound,
  output logic                     Busy,
  output logic                     Selected
);
  typedef enum logic [3:0] {IDLE, ADDR, LOOKUP, ACK, WR_BYTE, RD_LOAD, RD_BYTE, RD_ACK, WAIT_STOP} state_t;
  state_t r_state, w_state;
  logic [2:0] r_scl, r_sda;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_sh, w_sh, r_wdata, w_wdata, w_byte;
  logic [ADDRESSLENGTH-1:0] r_addr, w_addr;
  logic r_pull, w_pull, r_en, w_en, r_mode, w_mode, r_mrw, w_mrw;
  logic r_rw, w_rw, r_busy, w_busy, r_sel, w_sel;
  logic w_rise, w_fall, w_start, w_stop;
  // bits [1:0] are the synchronizer, bit [2] the previous synchronized value
  assign w_rise  = r_scl[1] & ~r_scl[2];
  assign w_fall  = ~r_scl[1] & r_scl[2];
  assign w_start = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
  assign w_stop  = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];
  assign w_byte  = {r_sh[6:0], r_sda[1]};
  assign SdaPullLow = r_pull;
  assign MemEnable  = r_en;
  assign MemMode    = r_mode;
  assign MemRorW    = r_mrw;
  assign MemAddress = r_addr;
  assign MemWrData  = r_wdata;
  assign Busy       = r_busy;
  assign Selected   = r_sel;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_scl   <= '1;
      r_sda   <= '1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_pull  <= 1'b0;
      r_en    <= 1'b0;
      r_mode  <= 1'b0;
      r_mrw   <= 1'b0;
      r_rw    <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_scl   <= {r_scl[1:0], Scl};
      r_sda   <= {r_sda[1:0], SdaIn};
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_wdata <= w_wdata;
      r_addr  <= w_addr;
      r_pull  <= w_pull;
      r_en    <= w_en;
      r_mode  <= w_mode;
      r_mrw   <= w_mrw;
      r_rw    <= w_rw;
      r_busy  <= w_busy;
      r_sel   <= w_sel;
    end
  end
  // LOOKUP and RD_LOAD wait out the strobe cycle (r_en high) before taking the memory reply
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_wdata = r_wdata;
    w_addr  = r_addr;
    w_pull  = r_pull;
    w_en    = 1'b0;
    w_mode  = r_mode;
    w_mrw   = r_mrw;
    w_rw    = r_rw;
    w_busy  = r_busy;
    w_sel   = r_sel;
    if (w_stop) begin
      w_state = IDLE;
      w_pull  = 1'b0;
      w_busy  = 1'b0;
      w_sel   = 1'b0;
    end else if (w_start) begin
      w_state = ADDR;
      w_cnt   = '0;
      w_sh    = '0;
      w_pull  = 1'b0;
      w_busy  = 1'b1;
    end else begin
      case (r_state)
        ADDR: if (w_rise) begin
          w_sh  = w_byte;
          w_cnt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_addr  = ADDRESSLENGTH'(w_byte[7:1]);
            w_rw    = w_byte[0];
            w_mode  = 1'b0;
            w_en    = 1'b1;
            w_cnt   = '0;
            w_state = LOOKUP;
          end
        end
        LOOKUP: if (!r_en) begin
          w_state = AddressFound ? ACK : WAIT_STOP;
          w_sel   = AddressFound;
        end
        // r_cnt marks whether the ACK low is already being driven
        ACK: if (w_fall) begin
          w_pull  = (r_cnt == 4'd0);
          w_cnt   = (r_cnt == 4'd0) ? 4'd1 : 4'd0;
          w_state = (r_cnt == 4'd0) ? ACK : WR_BYTE;
        end else if (w_rise && r_cnt == 4'd1 && r_rw) begin
          w_cnt   = '0;
          w_en    = 1'b1;
          w_mode  = 1'b1;
          w_mrw   = 1'b0;
          w_state = RD_LOAD;
        end
        WR_BYTE: if (w_rise) begin
          w_sh  = w_byte;
          w_cnt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_wdata = w_byte;
            w_en    = 1'b1;
            w_mode  = 1'b1;
            w_mrw   = 1'b1;
            w_cnt   = '0;
            w_state = ACK;
          end
        end
        RD_LOAD: if (!r_en) begin
          w_sh    = MemRdData;
          w_state = RD_BYTE;
        end
        RD_BYTE: if (w_fall) begin
          w_pull  = (r_cnt == 4'd8) ? 1'b0 : ~r_sh[7];
          w_sh    = {r_sh[6:0], 1'b0};
          w_cnt   = (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
          w_state = (r_cnt == 4'd8) ? RD_ACK : RD_BYTE;
        end
        RD_ACK: if (w_rise) begin
          w_state = r_sda[1] ? WAIT_STOP : RD_LOAD;
          w_en    = ~r_sda[1];
          w_mode  = r_sda[1] ? r_mode : 1'b1;
          w_mrw   = r_sda[1] ? r_mrw : 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb_i2c_slave_controller: bit-level I2C master plus a memory model driving a table of
// bus operations, followed by abort and reset-mid-read sequences.
`timescale 1ns/1ps
module tb_i2c_slave_controller;
  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_CHK} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] d;
    logic [7:0] exp;
    logic       af;
    logic       busy;
    logic       sel;
    int         nl;
    int         nw;
    int         nr;
  } vec_t;

  logic Clk = 1'b0, nReset = 1'b0, Scl = 1'b1, sda_m = 1'b1, SdaIn;
  logic SdaPullLow, MemEnable, MemMode, MemRorW, Busy, Selected;
  logic [7:0] MemAddress, MemWrData;
  logic [7:0] MemRdData = 8'h00;
  logic AddressFound = 1'b0, af_cfg = 1'b0, prev_en = 1'b0;
  logic [7:0] rd_tab [4] = '{8'h55, 8'hF5, 8'h3C, 8'h00};
  logic [7:0] last_addr = 8'h00, last_wd = 8'h00;
  int rd_idx = 0, n_l = 0, n_w = 0, n_r = 0, n_dbl = 0;
  int n_assert = 0, n_fail = 0;
  int bl = 0, bw = 0, br = 0;

  assign SdaIn = sda_m & ~SdaPullLow;
  always #5 Clk = ~Clk;

  i2c_slave_controller #(.ADDRESSLENGTH(8)) dut (
    .Clk(Clk), .nReset(nReset), .Scl(Scl), .SdaIn(SdaIn), .SdaPullLow(SdaPullLow),
    .MemEnable(MemEnable), .MemMode(MemMode), .MemRorW(MemRorW), .MemAddress(MemAddress),
    .MemWrData(MemWrData), .MemRdData(MemRdData), .AddressFound(AddressFound),
    .Busy(Busy), .Selected(Selected)
  );

  // memory model: replies are valid the Clk after a strobe
  always @(posedge Clk) begin
    prev_en <= MemEnable;
    if (MemEnable && prev_en) n_dbl <= n_dbl + 1;
    if (MemEnable) begin
      if (!MemMode) begin
        AddressFound <= af_cfg;
        n_l <= n_l + 1;
        last_addr <= MemAddress;
      end else if (MemRorW) begin
        n_w <= n_w + 1;
        last_wd <= MemWrData;
      end else begin
        MemRdData <= rd_tab[rd_idx % 4];
        rd_idx <= rd_idx + 1;
        n_r <= n_r + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wbit(input logic b);
    sda_m = b; #100; Scl = 1'b1; #200; Scl = 1'b0; #100;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #100; Scl = 1'b1; #100; b = SdaIn; #100; Scl = 1'b0; #100;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack);
  endtask

  task automatic start_c();
    sda_m = 1'b1; #100; Scl = 1'b1; #100; sda_m = 1'b0; #100; Scl = 1'b0; #100;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #100; Scl = 1'b1; #100; sda_m = 1'b1; #100;
  endtask

  vec_t v [26];
  logic b;
  logic [7:0] byt;

  initial begin
    v[0]  = '{OP_START, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    v[1]  = '{OP_WR,    8'h2E, 8'h01, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    v[2]  = '{OP_WR,    8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    v[3]  = '{OP_CHK,   8'h00, 8'h17, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    v[4]  = '{OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    v[5]  = '{OP_START, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    v[6]  = '{OP_WR,    8'hAA, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[7]  = '{OP_WR,    8'h55, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[8]  = '{OP_CHK,   8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 1, 1, 0};
    v[9]  = '{OP_WR,    8'hF5, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[10] = '{OP_CHK,   8'hF5, 8'h55, 1'b1, 1'b0, 1'b0, 0, 1, 0};
    v[11] = '{OP_STOP,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    v[12] = '{OP_START, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    v[13] = '{OP_WR,    8'hAB, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[14] = '{OP_RD,    8'h00, 8'h55, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[15] = '{OP_RD,    8'h01, 8'hF5, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[16] = '{OP_CHK,   8'hF5, 8'h55, 1'b1, 1'b0, 1'b0, 1, 0, 2};
    v[17] = '{OP_STOP,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    v[18] = '{OP_START, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    v[19] = '{OP_WR,    8'hAA, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[20] = '{OP_WR,    8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[21] = '{OP_START, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[22] = '{OP_WR,    8'hAB, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[23] = '{OP_RD,    8'h01, 8'h3C, 1'b1, 1'b1, 1'b1, 0, 0, 0};
    v[24] = '{OP_CHK,   8'h01, 8'h55, 1'b1, 1'b0, 1'b0, 2, 1, 1};
    v[25] = '{OP_STOP,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0};

    #23;
    check("rst_pull", SdaPullLow, 0);
    check("rst_en", MemEnable, 0);
    check("rst_busy", Busy, 0);
    check("rst_sel", Selected, 0);
    check("rst_addr", MemAddress, 0);
    nReset = 1'b1;
    #100;

    for (int i = 0; i < 26; i++) begin
      af_cfg = v[i].af;
      case (v[i].op)
        OP_START: start_c();
        OP_STOP:  stop_c();
        OP_WR: begin
          wbyte(v[i].d, b);
          check($sformatf("v%0d_ack", i), b, v[i].exp[0]);
        end
        OP_RD: begin
          rbyte(v[i].d[0], byt);
          check($sformatf("v%0d_rdbyte", i), byt, v[i].exp);
        end
        default: begin
          check($sformatf("v%0d_lookups", i), n_l - bl, v[i].nl);
          check($sformatf("v%0d_writes", i), n_w - bw, v[i].nw);
          check($sformatf("v%0d_reads", i), n_r - br, v[i].nr);
          check($sformatf("v%0d_addr", i), last_addr, v[i].exp);
          check($sformatf("v%0d_wdata", i), last_wd, v[i].d);
          bl = n_l; bw = n_w; br = n_r;
        end
      endcase
      if (v[i].op != OP_CHK) begin
        check($sformatf("v%0d_busy", i), Busy, v[i].busy);
        check($sformatf("v%0d_sel", i), Selected, v[i].sel);
      end
    end

    // abort: STOP after 4 bits of a write byte
    bl = n_l; bw = n_w; br = n_r;
    af_cfg = 1'b1;
    start_c();
    wbyte(8'hAA, b);
    check("abort_addr_ack", b, 0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    stop_c();
    #200;
    check("abort_busy", Busy, 0);
    check("abort_sel", Selected, 0);
    check("abort_pull", SdaPullLow, 0);
    check("abort_writes", n_w - bw, 0);
    check("abort_lookups", n_l - bl, 1);

    // reset while driving a read bit low (memory returns 0x00)
    start_c();
    wbyte(8'hAB, b);
    check("rstrd_ack", b, 0);
    check("rstrd_drive", SdaPullLow, 1);
    #30;
    nReset = 1'b0;
    #1;
    check("rstrd_pull", SdaPullLow, 0);
    check("rstrd_en", MemEnable, 0);
    check("rstrd_mode", MemMode, 0);
    check("rstrd_rorw", MemRorW, 0);
    check("rstrd_addr", MemAddress, 0);
    check("rstrd_wdata", MemWrData, 0);
    check("rstrd_busy", Busy, 0);
    check("rstrd_sel", Selected, 0);
    Scl = 1'b1; sda_m = 1'b1;
    #200;
    bl = n_l; bw = n_w; br = n_r;
    nReset = 1'b1;
    #500;
    check("rstrd_no_strobe", (n_l - bl) + (n_w - bw) + (n_r - br), 0);
    check("rstrd_busy_after", Busy, 0);
    check("no_double_enable", n_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_controller.md
I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 The block SHALL have parameter ADDRESSLENGTH, default 8, giving the width of MemAddress.
REQ-002 Clk  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-003 nReset  in  1  reset, asynchronous assert and active-low.
REQ-004 Scl  in  1  I2C clock from the bus, asynchronous to Clk.
REQ-005 SdaIn  in  1  I2C data from the bus, asynchronous to Clk.
REQ-006 SdaPullLow  out  1  open-drain drive; 1 SHALL pull SDA low, and 0 SHALL release it.
REQ-007 MemEnable  out  1  single-Clk strobe to the slave memory.
REQ-008 MemMode  out  1  0 = address lookup, 1 = data access.
REQ-009 MemRorW  out  1  1 = write, 0 = read; meaningful only when MemMode=1.
REQ-010 MemAddress  out  ADDRESSLENGTH  received 7-bit address, zero-extended.
REQ-011 MemWrData  out  8  byte received from the master.
REQ-012 MemRdData  in  8  byte from memory, valid the Clk after a read strobe.
REQ-013 AddressFound  in  1  memory hit flag, valid the Clk after a lookup strobe.
REQ-014 Busy  out  1  1 from START to STOP.
REQ-015 Selected  out  1  1 while the address has been ACKed and the transaction is open.

Function
REQ-016 Scl and SdaIn SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized values only.
REQ-017 A START (SDA fall while SCL high) SHALL move the FSM to ADDR from any state, including a repeated START.
REQ-018 A STOP (SDA rise while SCL high) SHALL move the FSM to IDLE from any state, release SDA, and clear Busy and Selected.
REQ-019 The FSM states SHALL be IDLE, ADDR, LOOKUP, ACK, WR_BYTE, RD_LOAD, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-020 In ADDR, WR_BYTE and RD_ACK, SDA SHALL be sampled on each SCL rise, MSB first.
REQ-021 SdaPullLow SHALL change only on the Clk following an SCL fall.
REQ-022 After the 8th ADDR bit: MemAddress = {0, bits[7:1]}, the R/W bit = bit[0], MemMode=0, and a one-Clk MemEnable pulse, then the FSM SHALL go to LOOKUP.
REQ-023 LOOKUP SHALL sample AddressFound one Clk after the strobe.
REQ-024 On a LOOKUP hit, the block SHALL ACK by driving SdaPullLow=1 from the next SCL fall until the following SCL fall, and set Selected.
REQ-025 On a LOOKUP miss, the block SHALL leave SDA released (NACK) and go to WAIT_STOP, with no further Mem strobes.
REQ-026 After an address ACK, R/W=0 SHALL lead to WR_BYTE and R/W=1 SHALL lead to RD_LOAD.
REQ-027 When a WR_BYTE completes (8th SCL rise), MemWrData SHALL take the byte and MemEnable SHALL pulse with MemMode=1, MemRorW=1; the block SHALL ACK the byte, then return to WR_BYTE.
REQ-028 In RD_LOAD, MemEnable SHALL pulse with MemMode=1, MemRorW=0; MemRdData SHALL be latched into the shift register the next Clk, and the FSM SHALL go to RD_BYTE.
REQ-029 In RD_BYTE, on each SCL fall SdaPullLow SHALL equal NOT(current bit), MSB first; after 8 bits SDA SHALL be released for the master ACK bit.
REQ-030 In RD_ACK, master ACK (SDA=0 at the 9th SCL rise) SHALL lead to RD_LOAD, and NACK SHALL lead to WAIT_STOP.
REQ-031 A START or STOP mid-byte SHALL discard the partial byte and issue no Mem strobe.
REQ-032 MemEnable SHALL never be high for two consecutive Clk cycles.

Reset
REQ-033 While nReset=0: state=IDLE; SdaPullLow, MemEnable, MemMode, MemRorW, Busy, Selected = 0; MemAddress, MemWrData, shift register, bit counter = 0; synchronizers = 1.
REQ-034 An asynchronous reset mid-transfer SHALL release SDA immediately and SHALL NOT generate a MemEnable pulse on deassertion.

Verification
REQ-035 Address miss: START, byte 0x2E, AddressFound=0 -> one lookup strobe with MemAddress=0x17, SDA released at the 9th clock, no data strobes, Busy until STOP.
REQ-036 Write: START, 0xAA (hit), 0x55, 0xF5, STOP -> three ACKs; write strobes with MemWrData=0x55 then 0xF5, MemRorW=1.
REQ-037 Read: START, 0xAB (hit), memory returns 0x55 then 0xF5, master ACK then NACK, STOP -> SDA bits 01010101 then 11110101; exactly two read strobes.
REQ-038 Repeated START: write 0xAA, 0x01, then START, 0xAB -> a new lookup strobe, then the read path; Selected stays 1.
REQ-039 Abort: STOP after 4 bits of a write byte -> IDLE, no write strobe.
REQ-040 Reset mid-read: nReset low during RD_BYTE -> SdaPullLow=0 in the same cycle, all outputs at reset values, no strobe after release.
